// File: rtl/up_data_framer.sv
// up_data_framer
//   Downstream stage of the 4-FIFO round-robin reader. Incoming words go into a
//   small FIFO. The block drives a registered stall back to the reader and
//   emits fixed-length frames on a valid/ready uplink:
//     header {SYNC_WORD, seq, PKT_WORDS}, then PKT_WORDS payload words,
//     then (optionally) a checksum tail {32'h0, sum}.
//   Optional feature macro: FRAMER_CHECKSUM_EN
//     defined   -> frame ends with the checksum tail word (tx_eop on the tail)
//     undefined -> no tail, tx_eop on the last payload word
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     data_valid, up_data incoming word stream (no backpressure on this side)
//     stall               registered; high while buffer level >= AFULL_LVL
//     tx_valid, tx_ready  uplink handshake
//     tx_data, tx_sop, tx_eop  uplink frame word and framing flags
//     overflow            sticky, a word was dropped because the buffer was full
//     frame_cnt           frames completed (eop accepted), wraps at 16 bits
module up_data_framer #(
  parameter int          DATA_W    = 64,
  parameter int          PKT_WORDS = 256,
  parameter int          BUF_DEPTH = 16,
  parameter int          AFULL_LVL = 12,
  parameter logic [31:0] SYNC_WORD = 32'hEB90_146F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              stall,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, PAY, TAIL} state_t;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level, level_next;
  logic              full, empty, push, pop, load, accept_eop, last_word;
  state_t            state, state_next;
  logic [15:0]       word_cnt, seq;

  logic              vld_p0, sop_p0, eop_p0;
  logic [DATA_W-1:0] data_p0;

`ifdef FRAMER_CHECKSUM_EN
  logic [31:0] sum;

  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [DATA_W-1:0] w);
    return acc + w[63:32] + w[31:0];
  endfunction
`endif

  // Stage 0: buffer bookkeeping. A write is allowed into a full buffer only
  // when a pop frees a slot in the same cycle.
  assign full       = (level == (AW+1)'(BUF_DEPTH));
  assign empty      = (level == '0);
  assign load       = !tx_valid || tx_ready;
  assign push       = data_valid && (!full || pop);
  assign level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign accept_eop = tx_valid && tx_ready && tx_eop;
  assign last_word  = (word_cnt == 16'(PKT_WORDS - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      stall <= (level_next >= (AW+1)'(AFULL_LVL));
      if (data_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // Stage 0: the FSM picks the next word to present. State advances when a
  // word is loaded into the output register; the register cannot reload
  // until that word is accepted, so this matches advancing on accept.
  always_comb begin
    state_next = state;
    vld_p0     = 1'b0;
    sop_p0     = 1'b0;
    eop_p0     = 1'b0;
    data_p0    = tx_data;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) state_next = HDR;
      HDR: if (load) begin
        vld_p0     = 1'b1;
        sop_p0     = 1'b1;
        data_p0    = DATA_W'({SYNC_WORD, seq, 16'(PKT_WORDS)});
        state_next = PAY;
      end
      PAY: if (load && !empty) begin
        pop     = 1'b1;
        vld_p0  = 1'b1;
        data_p0 = mem[rd_ptr];
        if (last_word) begin
`ifdef FRAMER_CHECKSUM_EN
          state_next = TAIL;
`else
          eop_p0     = 1'b1;
          state_next = IDLE;
`endif
        end
      end
`ifdef FRAMER_CHECKSUM_EN
      TAIL: if (load) begin
        vld_p0     = 1'b1;
        eop_p0     = 1'b1;
        data_p0    = DATA_W'({32'h0, sum});
        state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      seq       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == HDR && load) word_cnt <= '0;
      else if (pop)             word_cnt <= word_cnt + 16'd1;
      if (accept_eop) begin
        seq       <= seq + 16'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  // Every loaded payload word is eventually accepted (or wiped by reset), so
  // accumulating on pop gives the same sum as accumulating on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    sum <= '0;
    else if (state == HDR && load) sum <= '0;
    else if (pop)                  sum <= csum_add(sum, mem[rd_ptr]);
  end
`endif

  // Stage 1: output register, held while the uplink stalls. Data is left
  // unchanged during bubbles; only tx_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      tx_valid <= vld_p0;
      tx_sop   <= sop_p0;
      tx_eop   <= eop_p0;
      tx_data  <= data_p0;
    end
  end

endmodule
